tex_stream_sequencer: RTL
=========================

Name: tex_stream_sequencer

Overview:
Sequencer that streams one packed-ASCII LaTeX string per request from memory_chars, as a byte stream with valid/ready handshake. Latches a line id, drives the line_mapper lookup and selects the lhs or rhs start word from the returned pointer. Walks memory_chars word by word and unpacks each 16-bit word into two characters, high byte first, stopping at a NUL terminator. Sits between the top-level pins and the memory and line_mapper blocks, replacing direct parallel lhs/rhs output.

Parameters:
MAX_CHARS, 64, character limit per string; reaching it ends the string with truncated=1
READ_LATENCY, 1, cycles from a mem_addr change to valid mem_dout (1 or 2 supported)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
line_sel  input  7  [5:0] line id; [6] beacon request (see Optional Feature)
side_sel  input  1  0 = lhs (function), 1 = rhs (Laplace transform)
line  output  8  line id to line_mapper, {2'b0, line_sel[5:0]}
pointer_addr  input  16  from line_mapper: [15:8] lhs start word, [7:0] rhs start word
mem_addr  output  8  word address to memory_chars
mem_dout  input  16  packed chars: [15:8] first char, [7:0] second char
char_out  output  8  streamed ASCII character
char_valid  output  1  char_out valid
char_ready  input  1  consumer accepts char_out
busy  output  1  high from request acceptance until done
done  output  1  one-cycle pulse at end of string
truncated  output  1  with done: string ended by MAX_CHARS and not by NUL; held until next start

Behaviour:
- Reset (async assert, sync release): state IDLE. line=0, mem_addr=0, char_out=0, char_valid=0, busy=0, done=0, truncated=0, char count=0.
- States: IDLE -> LOOKUP -> FETCH -> WAIT -> EMIT_HI -> EMIT_LO -> FETCH ... -> FINISH -> IDLE.
- IDLE: on start=1, latch line_sel and side_sel, drive line, set busy=1, clear truncated, go to LOOKUP.
- LOOKUP: one cycle. Capture the pointer byte selected by side_sel into mem_addr. Go to FETCH.
- FETCH/WAIT: hold mem_addr for READ_LATENCY cycles, then register mem_dout into the word buffer.
- With READ_LATENCY=1, char_valid rises exactly 3 clk edges after the edge that sampled start.
- EMIT_HI: if buffer[15:8]==0, go to FINISH. Otherwise char_out=buffer[15:8], char_valid=1.
- EMIT_LO: if buffer[7:0]==0, go to FINISH. Otherwise char_out=buffer[7:0], char_valid=1. After its transfer, mem_addr increments and the sequencer goes to FETCH.
- Handshake: a transfer occurs on an edge where char_valid and char_ready are both 1. char_out stays stable while char_valid=1 and char_ready=0. char_valid never drops without a transfer.
- Back-to-back: char_ready held high gives one character per cycle within a word. Each word boundary costs READ_LATENCY+1 bubble cycles.
- Transferring the LO byte and arming the next fetch happen on the same edge.
- NUL is never emitted. A string that is empty at its first byte gives done with no characters.
- Count: increments per transfer. When the count reaches MAX_CHARS, go to FINISH with truncated=1, even if the next byte is NUL.
- mem_addr wraps from 0xFF to 0x00 modulo 256; only MAX_CHARS bounds the walk.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. A start in the same cycle as done is ignored.
- start while busy is ignored; no queueing.
- Reset mid-stream: immediate IDLE, char_valid drops asynchronously, no done pulse.

Optional Feature:
Macro CALLSIGN_BEACON_EN.
- Defined: a start with line_sel[6]=1 skips LOOKUP/FETCH and streams the constant "CQ DE KC1GPW" (12 chars) from an internal ROM.
  - Same handshake and the same done pulse; truncated=0.
  - First char_valid appears 1 edge after start is sampled.
- Undefined: line_sel[6] is ignored and normal memory streaming occurs. No beacon ROM logic is synthesized.

Test Plan:
1. mem[0x10]=0x5C66, mem[0x11]=0x0000, lhs pointer 0x10, side_sel=0, char_ready=1 -> chars 0x5C, 0x66, then done. No 0x00 emitted; first char_valid 3 edges after start.
2. rhs pointer 0x20, mem[0x20]=0x4100, side_sel=1 -> single char 0x41, then done; mem_addr never reaches 0x21.
3. Backpressure: char_ready toggled 1,0,0,1 on test 1 data -> char_out holds 0x66 across the stall cycles; exactly two transfers.
4. MAX_CHARS=4, 3 words of non-zero bytes -> exactly 4 chars, done with truncated=1. Pointer 0xFF reads 0xFF then 0x00.
5. start pulsed again mid-stream, then rst_n low for 1 cycle after char 1 -> second start ignored. After reset, all outputs at reset values; no done.
6. CALLSIGN_BEACON_EN defined, line_sel=7'h40 -> "CQ DE KC1GPW" then done. Undefined -> memory string for line 0.

Source files
------------

// File: rtl/tex_stream_sequencer_if.sv
// Signal bundle around tex_stream_sequencer: request pins, line_mapper lookup,
// memory_chars read port and the outgoing character stream.
interface tex_stream_sequencer_if;
    logic        start;
    logic [6:0]  line_sel;
    logic        side_sel;
    logic [7:0]  line;
    logic [15:0] pointer_addr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        truncated;

    modport master (
        input  start, line_sel, side_sel, pointer_addr, mem_dout, char_ready,
        output line, mem_addr, char_out, char_valid, busy, done, truncated
    );

    modport slave (
        output start, line_sel, side_sel, pointer_addr, mem_dout, char_ready,
        input  line, mem_addr, char_out, char_valid, busy, done, truncated
    );
endinterface

// File: rtl/tex_stream_sequencer.sv
// Streams one NUL-terminated packed-ASCII string per request as a valid/ready byte stream.
// Optional macro CALLSIGN_BEACON_EN adds a fixed callsign string selected by line_sel[6].
module tex_stream_sequencer #(
    parameter int unsigned MAX_CHARS    = 64,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    tex_stream_sequencer_if.master bus
);
    localparam int unsigned CNT_W = $clog2(MAX_CHARS + 1);
    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FETCH,
        S_WAIT,
        S_EMIT_HI,
        S_EMIT_LO,
        S_FINISH
`ifdef CALLSIGN_BEACON_EN
        , S_BEACON
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        line_q, line_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        char_q, char_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              trunc_q, trunc_d;
    logic              side_q, side_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LAT_W-1:0]  wait_q, wait_d;
    logic [7:0]        lo_q, lo_d;

    logic xfer_c;
    logic cnt_last_c;
    logic lat_done_c;

    assign xfer_c     = valid_q & bus.char_ready;
    assign cnt_last_c = (count_q == CNT_W'(MAX_CHARS - 1));
    assign lat_done_c = (wait_q == LAT_W'(READ_LATENCY - 1));

`ifdef CALLSIGN_BEACON_EN
    localparam logic [95:0] BEACON_TEXT = "CQ DE KC1GPW";
    localparam logic [3:0]  BEACON_LAST = 4'd11;

    logic [3:0] bidx_q, bidx_d;

    // First character sits in the top byte of the packed literal.
    function automatic logic [7:0] beacon_char(input logic [3:0] idx);
        logic [6:0] shift;
        shift = 7'd88 - {idx, 3'b000};
        return BEACON_TEXT[shift +: 8];
    endfunction
`else
    logic unused_beacon_sel;
    assign unused_beacon_sel = bus.line_sel[6];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
`ifdef CALLSIGN_BEACON_EN
                    state_d = bus.line_sel[6] ? S_BEACON : S_LOOKUP;
`else
                    state_d = S_LOOKUP;
`endif
                end
            end
            S_LOOKUP: state_d = S_FETCH;
            S_FETCH:  state_d = S_WAIT;
            S_WAIT: begin
                if (lat_done_c) begin
                    state_d = (bus.mem_dout[15:8] == 8'd0) ? S_FINISH : S_EMIT_HI;
                end
            end
            S_EMIT_HI: begin
                if (xfer_c) begin
                    state_d = (cnt_last_c || (lo_q == 8'd0)) ? S_FINISH : S_EMIT_LO;
                end
            end
            S_EMIT_LO: begin
                if (xfer_c) begin
                    state_d = cnt_last_c ? S_FINISH : S_FETCH;
                end
            end
`ifdef CALLSIGN_BEACON_EN
            S_BEACON: begin
                if (xfer_c && (bidx_q == BEACON_LAST)) begin
                    state_d = S_FINISH;
                end
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; done is a one-cycle pulse on entry to FINISH
    always_comb begin
        line_d  = line_q;
        addr_d  = addr_q;
        char_d  = char_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        trunc_d = trunc_q;
        side_d  = side_q;
        count_d = count_q;
        wait_d  = wait_q;
        lo_d    = lo_q;
`ifdef CALLSIGN_BEACON_EN
        bidx_d  = bidx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    line_d  = {2'b00, bus.line_sel[5:0]};
                    side_d  = bus.side_sel;
                    busy_d  = 1'b1;
                    trunc_d = 1'b0;
                    count_d = '0;
`ifdef CALLSIGN_BEACON_EN
                    bidx_d  = 4'd0;
`endif
                end
            end
            S_LOOKUP: begin
                addr_d = side_q ? bus.pointer_addr[7:0] : bus.pointer_addr[15:8];
            end
            S_FETCH: begin
                wait_d = '0;
            end
            S_WAIT: begin
                if (lat_done_c) begin
                    lo_d = bus.mem_dout[7:0];
                    if (bus.mem_dout[15:8] == 8'd0) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        char_d  = bus.mem_dout[15:8];
                        valid_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + LAT_W'(1);
                end
            end
            S_EMIT_HI: begin
                if (xfer_c) begin
                    count_d = count_q + CNT_W'(1);
                    if (cnt_last_c || (lo_q == 8'd0)) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        trunc_d = cnt_last_c;
                    end else begin
                        char_d = lo_q;
                    end
                end
            end
            S_EMIT_LO: begin
                if (xfer_c) begin
                    count_d = count_q + CNT_W'(1);
                    valid_d = 1'b0;
                    if (cnt_last_c) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        trunc_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 8'd1;
                    end
                end
            end
`ifdef CALLSIGN_BEACON_EN
            // First BEACON cycle loads char 0; afterwards each transfer loads the next one.
            S_BEACON: begin
                if (!valid_q) begin
                    char_d  = beacon_char(bidx_q);
                    valid_d = 1'b1;
                end else if (xfer_c) begin
                    if (bidx_q == BEACON_LAST) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        bidx_d = bidx_q + 4'd1;
                        char_d = beacon_char(bidx_q + 4'd1);
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q  <= 8'd0;
            addr_q  <= 8'd0;
            char_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            trunc_q <= 1'b0;
            side_q  <= 1'b0;
            count_q <= '0;
            wait_q  <= '0;
            lo_q    <= 8'd0;
`ifdef CALLSIGN_BEACON_EN
            bidx_q  <= 4'd0;
`endif
        end else begin
            line_q  <= line_d;
            addr_q  <= addr_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            trunc_q <= trunc_d;
            side_q  <= side_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            lo_q    <= lo_d;
`ifdef CALLSIGN_BEACON_EN
            bidx_q  <= bidx_d;
`endif
        end
    end

    assign bus.line       = line_q;
    assign bus.mem_addr   = addr_q;
    assign bus.char_out   = char_q;
    assign bus.char_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.truncated  = trunc_q;
endmodule
